// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, computes ALU/multiply/iterative-divide results,
// drives the data SRAM request and forwards dest/value back to decode.

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    // op bits: add sub slt sltu and nor or xor sll srl sra lui
    logic [31:0] sra_res;
    assign sra_res = $signed(alu_src1) >>> alu_src2[4:0];

    always_comb begin
        alu_result = 32'b0;
        if (alu_op[0])  alu_result = alu_result | (alu_src1 + alu_src2);
        if (alu_op[1])  alu_result = alu_result | (alu_src1 - alu_src2);
        if (alu_op[2])  alu_result = alu_result | {31'b0, $signed(alu_src1) < $signed(alu_src2)};
        if (alu_op[3])  alu_result = alu_result | {31'b0, alu_src1 < alu_src2};
        if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[8])  alu_result = alu_result | (alu_src1 << alu_src2[4:0]);
        if (alu_op[9])  alu_result = alu_result | (alu_src1 >> alu_src2[4:0]);
        if (alu_op[10]) alu_result = alu_result | sra_res;
        if (alu_op[11]) alu_result = alu_result | alu_src2;
    end
endmodule

module exe_stage #(
    parameter int DIV_ITER = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [154:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [70:0]  es_to_ms_bus,
    output logic [4:0]   es_to_ds_dest,
    output logic [31:0]  es_to_ds_value,
    output logic         es_value_from_mem,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    localparam int CW = $clog2(DIV_ITER) + 1;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    logic         es_valid;
    logic [154:0] es_bus;
    logic         es_ready_go;

    // mul_div_op[0..6] = mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu
    logic [6:0]  mul_div_op;
    logic [31:0] es_pc, src1, src2, rkd_value, alu_result, es_result;
    logic [11:0] alu_op;
    logic        res_from_mem, mem_we, gr_we;
    logic [4:0]  dest;

    assign {mul_div_op, es_pc, alu_op, src1, src2, rkd_value,
            res_from_mem, mem_we, dest, gr_we} = es_bus;

    logic is_div, is_signed_div;
    assign is_div        = |mul_div_op[6:3];
    assign is_signed_div = mul_div_op[3] | mul_div_op[4];

    alu u_alu (
        .alu_op     (alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

    // One unsigned multiplier; the signed high word is corrected from it.
    logic [63:0] prod_u;
    logic [31:0] mulh_s;
    assign prod_u = {32'b0, src1} * {32'b0, src2};
    assign mulh_s = prod_u[63:32] - (src1[31] ? src2 : 32'b0) - (src2[31] ? src1 : 32'b0);

    // Divider
    div_state_t    div_state, div_state_nxt;
    logic [CW-1:0] div_cnt;
    logic [31:0]   div_rem, div_quo, div_dsr;
    logic          neg_q, neg_r;
    logic          div_start, div_last;
    logic [32:0]   rem_sh;
    logic          rem_ge;
    logic [31:0]   quo_fix, rem_fix;

    assign div_start = (div_state == DIV_IDLE) && es_valid && is_div;
    assign div_last  = (div_cnt == CW'(DIV_ITER - 1));
    assign rem_sh    = {div_rem, div_quo[31]};
    assign rem_ge    = rem_sh >= {1'b0, div_dsr};
    assign quo_fix   = neg_q ? -div_quo : div_quo;
    assign rem_fix   = neg_r ? -div_rem : div_rem;

    always_comb begin
        div_state_nxt = div_state;
        case (div_state)
            DIV_IDLE: if (div_start) div_state_nxt = DIV_BUSY;
            DIV_BUSY: if (div_last)  div_state_nxt = DIV_DONE;
            DIV_DONE: if (es_to_ms_valid && ms_allowin) div_state_nxt = DIV_IDLE;
            default:  div_state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) div_state <= DIV_IDLE;
        else         div_state <= div_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            div_rem <= '0;
            div_quo <= '0;
            div_dsr <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (div_start) begin
            div_cnt <= '0;
            div_rem <= '0;
            div_quo <= (is_signed_div && src1[31]) ? -src1 : src1;
            div_dsr <= (is_signed_div && src2[31]) ? -src2 : src2;
            neg_q   <= is_signed_div && (src1[31] ^ src2[31]) && (src2 != 32'b0);
            neg_r   <= is_signed_div && src1[31];
        end else if (div_state == DIV_BUSY) begin
            // Restoring step: a zero divisor naturally yields all-ones / dividend.
            div_cnt <= div_cnt + CW'(1);
            div_rem <= rem_ge ? (rem_sh[31:0] - div_dsr) : rem_sh[31:0];
            div_quo <= {div_quo[30:0], rem_ge};
        end
    end

    always_comb begin
        es_result = alu_result;
        if (mul_div_op[0])                       es_result = prod_u[31:0];
        else if (mul_div_op[1])                  es_result = mulh_s;
        else if (mul_div_op[2])                  es_result = prod_u[63:32];
        else if (mul_div_op[3] | mul_div_op[5])  es_result = quo_fix;
        else if (mul_div_op[4] | mul_div_op[6])  es_result = rem_fix;
    end

    // Pipeline handshake
    assign es_ready_go    = is_div ? (div_state == DIV_DONE) : 1'b1;
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         es_valid <= 1'b0;
        else if (es_allowin) es_valid <= ds_to_es_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                           es_bus <= '0;
        else if (ds_to_es_valid && es_allowin) es_bus <= ds_to_es_bus;
    end

    assign es_to_ms_bus      = {es_pc, res_from_mem, dest, gr_we, es_result};
    assign es_to_ds_dest     = (es_valid && gr_we) ? dest : 5'd0;
    assign es_to_ds_value    = es_result;
    assign es_value_from_mem = es_valid && (res_from_mem || (is_div && div_state != DIV_DONE));

    assign data_sram_en    = es_valid && (res_from_mem || mem_we) && ms_allowin;
    assign data_sram_we    = {4{mem_we && es_valid && ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;
endmodule
